// File: rtl/rtype_sequencer_pkg.sv
// rtype_sequencer_pkg: state encoding, funct/opcode codes and ALU selects shared by the sequencer.
package rtype_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_t;
  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_NOR = 3'b111;
endpackage

// File: rtl/rtype_sequencer_funct_decoder.sv
// funct_decoder: combinational opcode/funct -> ALU select and legality for R-type instructions.
module funct_decoder
  import rtype_sequencer_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_sel,
  output logic       legal
);
  logic [2:0] sel;
  logic       known;
  always_comb begin
    sel = funct == F_ADD ? ALU_ADD :
          funct == F_SUB ? ALU_SUB :
          funct == F_OR  ? ALU_OR  :
          funct == F_NOR ? ALU_NOR :
          funct == F_SLL ? ALU_SLL :
          funct == F_SRL ? ALU_SRL : ALU_AND;
    known = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLL, F_SRL};
    legal = opcode == OPCODE_RTYPE && known;
    alu_sel = legal ? sel : ALU_AND;
  end
endmodule

// File: rtl/rtype_sequencer.sv
// rtype_sequencer: multi-cycle fetch/decode/exec/writeback control for the R-type MIPS datapath.
module rtype_sequencer
  import rtype_sequencer_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16,
  parameter int              TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [2:0]       alu_sel,
  output logic             rf_we,
  output logic             illegal,
  output logic             bus_err,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);
  state_t          state;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic [7:0]      fcnt;
  logic            skip;
  logic [2:0]      dec_sel;
  logic            dec_legal;
  funct_decoder u_dec (
    .opcode (ir[31:26]),
    .funct  (ir[5:0]),
    .alu_sel(dec_sel),
    .legal  (dec_legal)
  );
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign shamt     = ir[10:6];
  assign imem_addr = pc;
  assign imem_req  = state == S_FETCH;
  assign busy      = state != S_IDLE;
  // skipped instructions and writes to $zero never reach the register file
  assign rf_we     = state == S_WB && !skip && rd != 5'd0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      alu_sel <= ALU_AND;
      illegal <= 1'b0;
      bus_err <= 1'b0;
      retired <= '0;
      fcnt    <= '0;
      skip    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state   <= S_FETCH;
          fcnt    <= '0;
          illegal <= 1'b0;
          bus_err <= 1'b0;
        end
        // ack takes priority over the timeout on the same edge
        S_FETCH: if (imem_ack) begin
          ir    <= imem_rdata;
          state <= S_DECODE;
        end else if (fcnt == 8'(TIMEOUT)) begin
          bus_err <= 1'b1;
          state   <= S_IDLE;
        end else fcnt <= fcnt + 8'd1;
        S_DECODE: begin
          alu_sel <= dec_sel;
          skip    <= !dec_legal;
          illegal <= illegal | !dec_legal;
          state   <= S_EXEC;
        end
        S_EXEC: state <= S_WB;
        S_WB: begin
          pc      <= pc + PC_W'(4);
          retired <= skip ? retired : retired + CNT_W'(1);
          fcnt    <= '0;
          state   <= stop ? S_IDLE : S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
